huffman_build_ctrl: RTL and testbench
=====================================

// Module: huffman_build_ctrl
// PURPOSE
// Sequencer for the 4-symbol Huffman path. Accepts four leaf weights over a valid/ready port.
// Builds the 7-entry node table: leaves 1-4, internal nodes 5-7, node 7 is the root.
// Drives the node table onto the info_node_1..7 inputs of the code generator.
// Waits a fixed settle time, then captures CODE_TABLE and presents it with a valid/ack handshake.
// PARAMETERS
// SETTLE_CYCLES  4  cycles between root creation and CODE_TABLE capture; must cover generator pipeline depth; >=1
// PORTS
// CLK          in   1   system clock, rising edge
// nRST         in   1   asynchronous active-low reset
// start        in   1   pulse: begin a new build; sampled only in IDLE
// sym_valid    in   1   sym_weight valid
// sym_ready    out  1   high only in LOAD
// sym_weight   in   8   leaf weight; leaves arrive in order 1,2,3,4
// info_node_1..info_node_7  out  13 each  node table to generator
// code_table_in  in  16   CODE_TABLE from the generator
// table_out    out  16   captured code table
// table_valid  out  1    table_out valid; held until acked
// table_ack    in   1    consumer accept; sampled only while table_valid=1
// busy         out  1    high in every state except IDLE
// BEHAVIOUR
// - Node format (13 bit):
//   - [12]   used
//   - [11:9] parent index 1-7; 0 = no parent
//   - [8:1]  weight
//   - [0]    leaf flag
// - Reset (async): state=IDLE, all info_node=0, table_out=0, table_valid=0, sym_ready=0, busy=0, counters=0.
// - FSM: IDLE -> LOAD -> MERGE -> SETTLE -> DONE -> IDLE.
// - IDLE
//   - start=1 -> LOAD.
//   - All info_node are cleared on the same edge.
// - LOAD
//   - sym_ready=1.
//   - On each sym_valid&sym_ready edge, write node k = {1,3'd0,sym_weight,1'b1}, k=1..4.
//   - After the 4th beat -> MERGE.
//   - sym_valid low stalls indefinitely.
// - MERGE: exactly 3 cycles, one merge per cycle, creating nodes 5, 6, 7 in order.
//   - Candidates: used=1 and parent=0.
//   - Pick the two lowest weights. Equal weights: lower index wins.
//   - Write both picks' parent field = new index.
//   - New node = {1,3'd0,sum,1'b0}.
//   - sum saturates at 8'hFF.
//   - After node 7 is written -> SETTLE.
// - SETTLE
//   - Count SETTLE_CYCLES cycles, then latch code_table_in into table_out.
//   - table_valid=1 on that same edge; -> DONE.
// - DONE
//   - table_valid held and table_out stable until table_ack=1.
//   - On that edge: table_valid=0, -> IDLE.
//   - info_node hold their values until the next start.
// - start outside IDLE: ignored.
// - sym_valid outside LOAD: ignored, no write.
// - Zero weights are legal and use the same tie rules.
// - nRST low in any state aborts immediately to the reset values; a partial table is discarded.
// - Latency: start edge to table_valid = 1 + 4 (min LOAD) + 3 + SETTLE_CYCLES cycles.
// STRUCTURE
// - Shared package:
//   - node field offsets
//   - NODE_W=13, NUM_LEAF=4, NUM_NODE=7
//   - FSM state encodings
// - Sub-module huff_min2_pick (combinational):
//   - in: 7 nodes
//   - out: idx_a, idx_b (3 bit each), where idx_a = lowest weight, ties to lower index
// - Node table and counters live in this module.
// TESTING
// - Reset mid-MERGE -> all outputs zero, busy=0; a following start rebuilds correctly.
// - Weights 5,3,2,1:
//   - node5 = w3 (children 4,3)
//   - node6 = w6 (children 2,5; tie on 3 goes to index 2 before 5)
//   - node7 = w11 (children 1,6)
//   - parent fields: n1=7, n2=6, n3=5, n4=5, n5=6, n6=7, n7=0
// - Weights 4,4,4,4:
//   - node5 from (1,2), node6 from (3,4), node7 from (5,6)
//   - weights 8, 8, 16
// - Weights FF,FF,FF,FF: node7 weight saturates to FF, no wrap.
// - sym_valid toggling 1,0,0,1,... plus start pulses during LOAD/MERGE:
//   - exactly 4 leaves written
//   - start has no effect
// - code_table_in=16'hA5C3 at capture, table_ack held low 10 cycles:
//   - table_out=A5C3 and table_valid=1 throughout
//   - ack -> IDLE next edge
//   - check capture occurs exactly SETTLE_CYCLES after node 7 is written

Source files
------------

// File: rtl/huffman_build_ctrl_pkg.sv
// Shared definitions for the 4-symbol Huffman tree builder: node layout,
// table sizes, FSM state encodings and small helper functions.
package huffman_build_ctrl_pkg;

    localparam int NODE_W   = 13;
    localparam int NUM_LEAF = 4;
    localparam int NUM_NODE = 7;

    // Bit offsets inside a 13-bit node word
    localparam int NODE_USED_BIT = 12;
    localparam int NODE_PAR_MSB  = 11;
    localparam int NODE_PAR_LSB  = 9;
    localparam int NODE_WT_MSB   = 8;
    localparam int NODE_WT_LSB   = 1;
    localparam int NODE_LEAF_BIT = 0;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_MERGE  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Node word; field order matches the bit offsets above
    typedef struct packed {
        logic       used;
        logic [2:0] parent;   // 1..7, 0 = no parent yet
        logic [7:0] weight;
        logic       leaf;
    } node_t;

    // Build a used node with the given fields
    function automatic node_t make_node(input logic [2:0] parent,
                                        input logic [7:0] weight,
                                        input logic       leaf);
        node_t n;
        n.used   = 1'b1;
        n.parent = parent;
        n.weight = weight;
        n.leaf   = leaf;
        return n;
    endfunction

    // 8-bit add that clamps at 8'hFF instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/huffman_build_ctrl_min2_pick.sv
// Combinational selector: among nodes that are used and still parentless,
// returns the two with the lowest weights. Ties resolve to the lower index
// because the scan runs upward and only a strictly smaller weight replaces
// the current best. Index outputs are 1-based; 0 means nothing found.
module huff_min2_pick
    import huffman_build_ctrl_pkg::*;
(
    input  node_t [NUM_NODE-1:0] i_nodes,
    output logic  [2:0]          o_idx_a,
    output logic  [7:0]          o_wt_a,
    output logic  [2:0]          o_idx_b,
    output logic  [7:0]          o_wt_b
);

    logic w_found_a;
    logic w_found_b;

    // Lowest-weight candidate
    always_comb begin
        o_idx_a   = 3'd0;
        o_wt_a    = 8'd0;
        w_found_a = 1'b0;
        for (int k = 0; k < NUM_NODE; k++) begin
            if (i_nodes[k].used && (i_nodes[k].parent == 3'd0) &&
                (!w_found_a || (i_nodes[k].weight < o_wt_a))) begin
                w_found_a = 1'b1;
                o_wt_a    = i_nodes[k].weight;
                o_idx_a   = 3'(k + 1);
            end
        end
    end

    // Second-lowest candidate: same scan with the first pick excluded
    always_comb begin
        o_idx_b   = 3'd0;
        o_wt_b    = 8'd0;
        w_found_b = 1'b0;
        for (int k = 0; k < NUM_NODE; k++) begin
            if (i_nodes[k].used && (i_nodes[k].parent == 3'd0) &&
                (3'(k + 1) != o_idx_a) &&
                (!w_found_b || (i_nodes[k].weight < o_wt_b))) begin
                w_found_b = 1'b1;
                o_wt_b    = i_nodes[k].weight;
                o_idx_b   = 3'(k + 1);
            end
        end
    end

endmodule

// File: rtl/huffman_build_ctrl.sv
// Sequencer for the 4-symbol Huffman path. Loads four leaf weights, merges
// them into a 7-node tree (node 7 = root), drives the node table to the code
// generator, waits SETTLE_CYCLES, then captures and presents the code table.
//
// Handshakes:
//   Leaf input : a leaf is taken on a rising edge where sym_valid=1 and
//                sym_ready=1; sym_ready is high only in LOAD, so sym_valid
//                at any other time is ignored.
//   Table out  : table_valid rises with table_out on the capture edge and
//                both hold until an edge where table_ack=1; that edge drops
//                table_valid. table_ack is ignored while table_valid=0.
module huffman_build_ctrl
    import huffman_build_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [7:0]  sym_weight,
    output logic [12:0] info_node_1,
    output logic [12:0] info_node_2,
    output logic [12:0] info_node_3,
    output logic [12:0] info_node_4,
    output logic [12:0] info_node_5,
    output logic [12:0] info_node_6,
    output logic [12:0] info_node_7,
    input  logic [15:0] code_table_in,
    output logic [15:0] table_out,
    output logic        table_valid,
    input  logic        table_ack,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]                r_state;
    node_t [NUM_NODE-1:0]      r_node;
    logic [1:0]                r_load_cnt;
    logic [1:0]                r_merge_cnt;
    logic [SETTLE_W-1:0]       r_settle_cnt;
    logic [15:0]               r_table_out;
    logic                      r_table_valid;

    logic [2:0]                w_idx_a;
    logic [2:0]                w_idx_b;
    logic [7:0]                w_wt_a;
    logic [7:0]                w_wt_b;
    logic [7:0]                w_sum;
    logic [2:0]                w_new_idx;

    huff_min2_pick u_pick (
        .i_nodes (r_node),
        .o_idx_a (w_idx_a),
        .o_wt_a  (w_wt_a),
        .o_idx_b (w_idx_b),
        .o_wt_b  (w_wt_b)
    );

    assign w_sum     = sat_add8(w_wt_a, w_wt_b);
    // Merges create nodes 5, 6, 7 in order
    assign w_new_idx = 3'd5 + {1'b0, r_merge_cnt};

    // Main sequencer: FSM, node table, counters and captured table
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= ST_IDLE;
            r_node        <= '0;
            r_load_cnt    <= 2'd0;
            r_merge_cnt   <= 2'd0;
            r_settle_cnt  <= '0;
            r_table_out   <= 16'd0;
            r_table_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_node     <= '0;
                        r_load_cnt <= 2'd0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (sym_valid) begin
                        r_node[{1'b0, r_load_cnt}] <= make_node(3'd0, sym_weight, 1'b1);
                        r_load_cnt <= r_load_cnt + 2'd1;
                        if (r_load_cnt == 2'(NUM_LEAF - 1)) begin
                            r_merge_cnt <= 2'd0;
                            r_state     <= ST_MERGE;
                        end
                    end
                end
                ST_MERGE: begin
                    for (int k = 0; k < NUM_NODE; k++) begin
                        if (3'(k + 1) == w_new_idx) begin
                            r_node[k] <= make_node(3'd0, w_sum, 1'b0);
                        end else if ((3'(k + 1) == w_idx_a) || (3'(k + 1) == w_idx_b)) begin
                            r_node[k].parent <= w_new_idx;
                        end
                    end
                    r_merge_cnt <= r_merge_cnt + 2'd1;
                    if (r_merge_cnt == 2'd2) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        r_table_out   <= code_table_in;
                        r_table_valid <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_DONE: begin
                    if (table_ack) begin
                        r_table_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sym_ready   = (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);
    assign dbg_state   = r_state;
    assign table_out   = r_table_out;
    assign table_valid = r_table_valid;

    assign info_node_1 = r_node[0];
    assign info_node_2 = r_node[1];
    assign info_node_3 = r_node[2];
    assign info_node_4 = r_node[3];
    assign info_node_5 = r_node[4];
    assign info_node_6 = r_node[5];
    assign info_node_7 = r_node[6];

endmodule

// File: tb/tb_huffman_build_ctrl.sv
// Directed bench for huffman_build_ctrl: a table of weight vectors with
// hand-computed node tables, plus hand sequences for ack hold, stalls with
// ignored start pulses, and reset during MERGE.
module tb_huffman_build_ctrl;
  import huffman_build_ctrl_pkg::*;

  localparam int S = 4;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        sym_valid;
  logic        sym_ready;
  logic [7:0]  sym_weight;
  logic [12:0] info_node_1, info_node_2, info_node_3, info_node_4;
  logic [12:0] info_node_5, info_node_6, info_node_7;
  logic [15:0] code_table_in;
  logic [15:0] table_out;
  logic        table_valid;
  logic        table_ack;
  logic        busy;
  logic [2:0]  dbg_state;

  huffman_build_ctrl #(.SETTLE_CYCLES(S)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .start         (start),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_weight    (sym_weight),
    .info_node_1   (info_node_1),
    .info_node_2   (info_node_2),
    .info_node_3   (info_node_3),
    .info_node_4   (info_node_4),
    .info_node_5   (info_node_5),
    .info_node_6   (info_node_6),
    .info_node_7   (info_node_7),
    .code_table_in (code_table_in),
    .table_out     (table_out),
    .table_valid   (table_valid),
    .table_ack     (table_ack),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int t0;

  typedef struct {
    logic [3:0][7:0]  w;     // leaf weights, [0] = leaf 1
    logic [6:0][2:0]  par;   // expected parent per node, [0] = node 1
    logic [6:0][7:0]  wt;    // expected weight per node
    logic [15:0]      code;  // code_table_in value for this build
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [2:0] p1, input logic [2:0] p2,
                         input logic [2:0] p3, input logic [2:0] p4, input logic [2:0] p5,
                         input logic [2:0] p6, input logic [7:0] x5, input logic [7:0] x6,
                         input logic [7:0] x7);
    vec_t v;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.par[0] = p1; v.par[1] = p2; v.par[2] = p3; v.par[3] = p4;
    v.par[4] = p5; v.par[5] = p6; v.par[6] = 3'd0;
    v.wt[0] = a; v.wt[1] = b; v.wt[2] = c; v.wt[3] = d;
    v.wt[4] = x5; v.wt[5] = x6; v.wt[6] = x7;
    v.code = 16'h1000 + 16'(vecs.size() * 16'h0111);
    vecs.push_back(v);
  endtask

  function automatic logic [12:0] exp_node(input vec_t v, input int k);
    logic leaf;
    leaf = (k < 4);
    return {1'b1, v.par[k], v.wt[k], leaf};
  endfunction

  function automatic logic [12:0] get_node(input int k);
    case (k)
      0: return info_node_1;
      1: return info_node_2;
      2: return info_node_3;
      3: return info_node_4;
      4: return info_node_5;
      5: return info_node_6;
      6: return info_node_7;
      default: return 13'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge CLK); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic load4(input logic [3:0][7:0] w);
    for (int i = 0; i < 4; i++) begin
      sym_valid  = 1'b1;
      sym_weight = w[i];
      @(posedge CLK); #1;
    end
    sym_valid  = 1'b0;
    sym_weight = 8'd0;
  endtask

  task automatic wait_valid(output int t_n7, output int t_v);
    t_n7 = -1;
    t_v  = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (t_n7 < 0 && info_node_7[12]) t_n7 = cyc;
      if (table_valid) begin
        t_v = cyc;
        break;
      end
    end
  endtask

  task automatic check_nodes(input vec_t v, input string tag);
    for (int k = 0; k < 7; k++)
      chk($sformatf("%s node%0d", tag, k + 1), 32'(get_node(k)), 32'(exp_node(v, k)));
  endtask

  task automatic ack_table(input string tag);
    @(negedge CLK);
    table_ack = 1'b1;
    @(posedge CLK); #1;
    table_ack = 1'b0;
    chk({tag, " valid_after_ack"}, 32'(table_valid), 32'd0);
    chk({tag, " busy_after_ack"}, 32'(busy), 32'd0);
    chk({tag, " state_after_ack"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int tn7, tv;
    logic [15:0] e;
    code_table_in = v.code;
    exp_q.push_back(v.code);
    do_start();
    chk({tag, " sym_ready_in_load"}, 32'(sym_ready), 32'd1);
    load4(v.w);
    wait_valid(tn7, tv);
    chk({tag, " table_valid"}, 32'(table_valid), 32'd1);
    chk({tag, " latency"}, 32'(tv - t0), 32'(8 + S));
    chk({tag, " settle_gap"}, 32'(tv - tn7), 32'(S));
    e = exp_q.pop_front();
    chk({tag, " table_out"}, 32'(table_out), 32'(e));
    check_nodes(v, tag);
    ack_table(tag);
  endtask

  // ---------------- test ----------------
  initial begin
    int tn7, tv;
    logic [3:0][7:0] wl;
    logic [9:0] vpat;
    logic [9:0] spat;
    int li;

    nRST = 1'b0; start = 1'b0; sym_valid = 1'b0; sym_weight = 8'd0;
    code_table_in = 16'd0; table_ack = 1'b0;

    // vector table: leaf weights, parents of nodes 1-6, weights of nodes 5-7
    add_vec(8'd5,   8'd3,   8'd2,   8'd1,   3'd7, 3'd6, 3'd5, 3'd5, 3'd6, 3'd7, 8'd3,   8'd6,   8'd11);
    add_vec(8'd4,   8'd4,   8'd4,   8'd4,   3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 8'd8,   8'd8,   8'd16);
    add_vec(8'hFF,  8'hFF,  8'hFF,  8'hFF,  3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 8'hFF,  8'hFF,  8'hFF);
    add_vec(8'd0,   8'd0,   8'd0,   8'd0,   3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 8'd0,   8'd0,   8'd0);
    add_vec(8'd1,   8'd2,   8'd3,   8'd4,   3'd5, 3'd5, 3'd6, 3'd7, 3'd6, 3'd7, 8'd3,   8'd6,   8'd10);
    add_vec(8'd200, 8'd100, 8'd60,  8'd50,  3'd7, 3'd6, 3'd5, 3'd5, 3'd6, 3'd7, 8'd110, 8'd210, 8'hFF);

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 7; k++) chk($sformatf("reset node%0d", k + 1), 32'(get_node(k)), 32'd0);
    chk("reset table_out", 32'(table_out), 32'd0);
    chk("reset table_valid", 32'(table_valid), 32'd0);
    chk("reset sym_ready", 32'(sym_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge CLK); #1;
    nRST = 1'b1;

    // sym_valid in IDLE writes nothing
    sym_valid = 1'b1; sym_weight = 8'h77;
    repeat (2) @(posedge CLK);
    #1;
    sym_valid = 1'b0;
    chk("idle sym_valid node1", 32'(info_node_1), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);

    // table-driven builds
    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // capture A5C3, ack held low 10 cycles
    code_table_in = 16'hA5C3;
    do_start();
    load4(vecs[0].w);
    wait_valid(tn7, tv);
    chk("hold settle_gap", 32'(tv - tn7), 32'(S));
    chk("hold latency", 32'(tv - t0), 32'(8 + S));
    code_table_in = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("hold valid c%0d", i), 32'(table_valid), 32'd1);
      chk($sformatf("hold table_out c%0d", i), 32'(table_out), 32'hA5C3);
    end
    chk("hold busy", 32'(busy), 32'd1);
    ack_table("hold");
    repeat (3) @(posedge CLK);
    #1;
    check_nodes(vecs[0], "idle_hold");

    // stalled LOAD with start pulses during LOAD/MERGE and stray sym_valid
    code_table_in = 16'h3C3C;
    do_start();
    vpat = 10'b10_0110_1001;   // bit i = sym_valid in cycle i
    spat = 10'b01_1001_0010;   // bit i = start in cycle i
    li = 0;
    for (int i = 0; i < 10; i++) begin
      sym_valid = vpat[i];
      start     = spat[i];
      if (vpat[i] && li < 4) begin
        wl = vecs[0].w;
        sym_weight = wl[li];
        li++;
      end else begin
        sym_weight = 8'hEE;
      end
      @(posedge CLK); #1;
    end
    sym_valid = 1'b0; start = 1'b0; sym_weight = 8'd0;
    wait_valid(tn7, tv);
    chk("stall table_valid", 32'(table_valid), 32'd1);
    chk("stall table_out", 32'(table_out), 32'h3C3C);
    check_nodes(vecs[0], "stall");
    ack_table("stall");

    // reset in the middle of MERGE
    code_table_in = 16'h5A5A;
    do_start();
    load4(vecs[1].w);
    @(posedge CLK); #1;
    chk("pre_reset busy", 32'(busy), 32'd1);
    nRST = 1'b0;
    #1;
    for (int k = 0; k < 7; k++) chk($sformatf("midreset node%0d", k + 1), 32'(get_node(k)), 32'd0);
    chk("midreset table_out", 32'(table_out), 32'd0);
    chk("midreset table_valid", 32'(table_valid), 32'd0);
    chk("midreset sym_ready", 32'(sym_ready), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    run_vec(vecs[0], "rebuild");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
